// File: rtl/noc_pkg.sv
// Shared NoC router definitions: flit-type encodings, port indices,
// arbiter state encoding and small index helpers used by the router
// arbitration logic.
package noc_pkg;

  localparam int NPORTS = 5;

  // Flit type lives in the two MSBs of every flit.
  localparam logic [1:0] FT_BODY   = 2'b00;
  localparam logic [1:0] FT_HEAD   = 2'b01;
  localparam logic [1:0] FT_TAIL   = 2'b10;
  localparam logic [1:0] FT_SINGLE = 2'b11;

  // Input port indices; bit order of every 5-bit port vector.
  localparam logic [2:0] P_N = 3'd0;
  localparam logic [2:0] P_E = 3'd1;
  localparam logic [2:0] P_S = 3'd2;
  localparam logic [2:0] P_W = 3'd3;
  localparam logic [2:0] P_L = 3'd4;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } arb_state_t;

  // Next round-robin position after idx, wrapping 4 -> 0.
  function automatic logic [2:0] rr_next(input logic [2:0] idx);
    if (idx >= 3'd4) begin
      return 3'd0;
    end else begin
      return idx + 3'd1;
    end
  endfunction

  // One-hot port vector for a port index; out-of-range gives zero.
  function automatic logic [4:0] onehot5(input logic [2:0] idx);
    case (idx)
      3'd0:    return 5'b00001;
      3'd1:    return 5'b00010;
      3'd2:    return 5'b00100;
      3'd3:    return 5'b01000;
      3'd4:    return 5'b10000;
      default: return 5'b00000;
    endcase
  endfunction

endpackage

// File: rtl/out_port_arb_rr_arb5.sv
// rr_arb5: combinational 5-way round-robin pick.
// Ports:
//   req [4:0]  request vector (bit order N,E,S,W,L)
//   ptr [2:0]  highest-priority index; scan goes ptr, ptr+1, ... mod 5
//   gnt [4:0]  one-hot winner, zero when no request
//   idx [2:0]  winner index, 0 when no request
module rr_arb5
  import noc_pkg::*;
(
  input  logic [4:0] req,
  input  logic [2:0] ptr,
  output logic [4:0] gnt,
  output logic [2:0] idx
);

  logic       found_s;
  logic [3:0] sum_s;
  logic [2:0] cand_s;

  // Scan the five positions starting at ptr and take the first requester.
  always_comb begin
    gnt     = 5'b00000;
    idx     = 3'd0;
    found_s = 1'b0;
    sum_s   = 4'd0;
    cand_s  = 3'd0;
    for (int k = 0; k < NPORTS; k++) begin
      sum_s = {1'b0, ptr} + 4'(k);
      if (sum_s >= 4'd5) begin
        cand_s = 3'(sum_s - 4'd5);
      end else begin
        cand_s = sum_s[2:0];
      end
      // Range guard keeps an illegal pointer from selecting a phantom port.
      if (!found_s && (cand_s <= 3'd4) && req[cand_s]) begin
        found_s     = 1'b1;
        gnt[cand_s] = 1'b1;
        idx         = cand_s;
      end else begin
        found_s = found_s;
      end
    end
  end

endmodule

// File: rtl/out_port_arb.sv
// out_port_arb: per-output-port reader of the router input FIFO bank.
// Picks among the N/E/S/W/L FIFO heads routed here, pops the winner and
// registers the flit onto the output link. Wormhole: a HEAD locks the
// output to its input until the TAIL passes.
// Ports:
//   fifo_clk, rst                 clock, synchronous active-high reset
//   X_fifo_data / X_fifo_valid    FWFT head flit and non-empty per input
//   route_hit[4:0]                head of input i targets this output
//   fifo_ready_X                  combinational pop strobe per input
//   out_data / out_valid          registered flit to downstream FIFO
//   out_full_in                   downstream FIFO full
//   out_grant / out_locked        current owner (one-hot) / packet open
//   proto_err                     sticky protocol-error flag
module out_port_arb
  import noc_pkg::*;
#(
  parameter int         DATASIZE = 40,
  parameter logic [2:0] RR_INIT  = 3'd0
) (
  input  logic                fifo_clk,
  input  logic                rst,
  input  logic [DATASIZE-1:0] N_fifo_data,
  input  logic [DATASIZE-1:0] E_fifo_data,
  input  logic [DATASIZE-1:0] S_fifo_data,
  input  logic [DATASIZE-1:0] W_fifo_data,
  input  logic [DATASIZE-1:0] L_fifo_data,
  input  logic                N_fifo_valid,
  input  logic                E_fifo_valid,
  input  logic                S_fifo_valid,
  input  logic                W_fifo_valid,
  input  logic                L_fifo_valid,
  input  logic [4:0]          route_hit,
  output logic                fifo_ready_N,
  output logic                fifo_ready_E,
  output logic                fifo_ready_S,
  output logic                fifo_ready_W,
  output logic                fifo_ready_L,
  output logic [DATASIZE-1:0] out_data,
  output logic                out_valid,
  input  logic                out_full_in,
  output logic [4:0]          out_grant,
  output logic                out_locked,
  output logic                proto_err
);

  arb_state_t          state_r;
  logic [2:0]          owner_r;
  logic [2:0]          rr_ptr_r;
  logic                bad_seen_r;

  logic [DATASIZE-1:0] data_s [NPORTS];
  logic [4:0]          valid_s;
  logic [4:0]          req_s;
  logic [4:0]          eligible_s;
  logic [4:0]          arb_gnt_s;
  logic [2:0]          arb_idx_s;
  logic [4:0]          sel_s;
  logic [4:0]          pop_s;
  logic [2:0]          pop_idx_s;
  logic                pop_any_s;
  logic [DATASIZE-1:0] pop_data_s;
  logic [1:0]          pop_ft_s;
  logic                load_en_s;
  logic                bad_only_s;

  assign data_s[0] = N_fifo_data;
  assign data_s[1] = E_fifo_data;
  assign data_s[2] = S_fifo_data;
  assign data_s[3] = W_fifo_data;
  assign data_s[4] = L_fifo_data;
  assign valid_s   = {L_fifo_valid, W_fifo_valid, S_fifo_valid, E_fifo_valid, N_fifo_valid};

  // Output register may load when empty or when its flit leaves this cycle.
  assign load_en_s = !out_valid || !out_full_in;

  // Requesters and packet-start eligibility per input head.
  always_comb begin
    req_s      = 5'b00000;
    eligible_s = 5'b00000;
    for (int i = 0; i < NPORTS; i++) begin
      req_s[i]      = valid_s[i] && route_hit[i];
      eligible_s[i] = req_s[i] &&
                      ((data_s[i][DATASIZE-1 -: 2] == FT_HEAD) ||
                       (data_s[i][DATASIZE-1 -: 2] == FT_SINGLE));
    end
  end

  rr_arb5 u_rr_arb5 (
    .req (eligible_s),
    .ptr (rr_ptr_r),
    .gnt (arb_gnt_s),
    .idx (arb_idx_s)
  );

  // Select source (arbiter when idle, owner when locked) and form the pop strobes.
  always_comb begin
    sel_s     = 5'b00000;
    pop_idx_s = 3'd0;
    pop_s     = 5'b00000;
    if (state_r == ST_LOCKED) begin
      // Owner only: route_hit is ignored and empty-owner bubbles are not filled.
      sel_s     = onehot5(owner_r);
      pop_idx_s = owner_r;
    end else begin
      sel_s     = arb_gnt_s;
      pop_idx_s = arb_idx_s;
    end
    if (rst) begin
      pop_s = 5'b00000;
    end else begin
      pop_s = sel_s & valid_s & {5{load_en_s}};
    end
  end

  assign pop_any_s = |pop_s;

  // Mux the popped flit.
  always_comb begin
    if (pop_idx_s <= 3'd4) begin
      pop_data_s = data_s[pop_idx_s];
    end else begin
      pop_data_s = {DATASIZE{1'b0}};
    end
  end

  assign pop_ft_s = pop_data_s[DATASIZE-1 -: 2];

  // A lone idle requester that cannot start a packet (BODY/TAIL at its head).
  always_comb begin
    if ((state_r == ST_IDLE) && (req_s != 5'b00000) &&
        ((req_s & (req_s - 5'd1)) == 5'b00000) &&
        ((req_s & eligible_s) == 5'b00000)) begin
      bad_only_s = 1'b1;
    end else begin
      bad_only_s = 1'b0;
    end
  end

  assign fifo_ready_N = pop_s[P_N];
  assign fifo_ready_E = pop_s[P_E];
  assign fifo_ready_S = pop_s[P_S];
  assign fifo_ready_W = pop_s[P_W];
  assign fifo_ready_L = pop_s[P_L];

  // Output stage, wormhole lock FSM, round-robin pointer and error flag.
  always_ff @(posedge fifo_clk) begin
    if (rst) begin
      out_data   <= {DATASIZE{1'b0}};
      out_valid  <= 1'b0;
      state_r    <= ST_IDLE;
      owner_r    <= 3'd0;
      out_grant  <= 5'b00000;
      out_locked <= 1'b0;
      proto_err  <= 1'b0;
      rr_ptr_r   <= RR_INIT;
      bad_seen_r <= 1'b0;
    end else begin
      if (load_en_s) begin
        if (pop_any_s) begin
          out_data  <= pop_data_s;
          out_valid <= 1'b1;
        end else begin
          out_valid <= 1'b0;
        end
      end else begin
        out_valid <= out_valid;
      end

      bad_seen_r <= bad_only_s;
      if (bad_only_s && bad_seen_r) begin
        proto_err <= 1'b1;
      end else begin
        proto_err <= proto_err;
      end

      case (state_r)
        ST_IDLE: begin
          if (pop_any_s) begin
            if (pop_ft_s == FT_HEAD) begin
              state_r    <= ST_LOCKED;
              owner_r    <= pop_idx_s;
              out_grant  <= onehot5(pop_idx_s);
              out_locked <= 1'b1;
            end else begin
              rr_ptr_r <= rr_next(pop_idx_s);
            end
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_LOCKED: begin
          if (pop_any_s && (pop_ft_s != FT_BODY)) begin
            // A new HEAD/SINGLE inside a packet is flagged and closes the packet.
            if (pop_ft_s != FT_TAIL) begin
              proto_err <= 1'b1;
            end else begin
              proto_err <= proto_err;
            end
            state_r    <= ST_IDLE;
            out_grant  <= 5'b00000;
            out_locked <= 1'b0;
            rr_ptr_r   <= rr_next(owner_r);
          end else begin
            state_r <= ST_LOCKED;
          end
        end
        default: begin
          state_r    <= ST_IDLE;
          out_grant  <= 5'b00000;
          out_locked <= 1'b0;
        end
      endcase
    end
  end

endmodule
